// File: rtl/pc_next_unit.sv
// ============================================================================
// Module   : pc_next_unit
// Brief    : RV32 fetch PC register with next-PC select, trap redirect and a
//            circular return-address stack. Optional macro PC_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_req,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    input  logic            ras_flush,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;
    logic               w_empty;
    logic               w_full;
    logic [XLEN-1:0]    w_top;
    logic [XLEN-1:0]    w_target;
    logic               w_redirect;
    logic               w_misalign;
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;

    // Explicit wrap so non-power-of-two depths stay circular
    assign w_ptr_inc = (r_ptr == c_PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptr_dec = (r_ptr == '0) ? c_PTR_W'(RAS_DEPTH - 1) : r_ptr - 1'b1;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == c_CNT_W'(RAS_DEPTH));
    assign w_top      = w_empty ? '0 : r_ras[r_ptr];
    assign w_redirect = (pc_sel != 2'b00);

    assign pc        = r_pc;
    assign pc_plus4  = r_pc + XLEN'(4);
    assign ras_top   = w_top;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;

    always_comb begin
        w_target = pc_plus4;
        case (pc_sel)
            2'b01:   w_target = branch_target;
            2'b10:   w_target = w_empty ? pc_plus4 : w_top;
            2'b11:   w_target = {alu_result[XLEN-1:1], 1'b0};
            default: w_target = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misalign = w_redirect && (w_target[1:0] != 2'b00);
    assign misalign   = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign misalign   = 1'b0;
`endif

    // Redirects and traps take effect even while the hazard unit stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else if (trap_req || w_misalign) begin
            r_pc <= TRAP_VEC;
        end else if (w_redirect) begin
            r_pc <= w_target;
        end else if (!stall) begin
            r_pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (ras_flush) begin
            r_cnt <= '0;
        end else if (ras_push && ras_pop && !w_empty) begin
            r_cnt <= r_cnt;
        end else if (ras_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (ras_pop && !w_empty) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Push+pop on a non-empty stack replaces the top entry in place
    assign w_wr_en  = !rst && !ras_flush && ras_push;
    assign w_wr_idx = (ras_pop && !w_empty) ? r_ptr : w_ptr_inc;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= ras_push_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// Module   : tb_pc_next_unit
// Brief    : Directed self-checking bench for pc_next_unit with a queue-based
//            reference model. Honours PC_MISALIGN_TRAP_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_next_unit;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_RESET = 32'h0000_0000;
    localparam logic [31:0] c_TRAP  = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap_req;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic        ras_flush;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;

    pc_next_unit #(
        .XLEN      (32),
        .RESET_VEC (c_RESET),
        .TRAP_VEC  (c_TRAP),
        .RAS_DEPTH (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap_req      (trap_req),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .alu_result    (alu_result),
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .ras_pop       (ras_pop),
        .ras_flush     (ras_flush),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_top       (ras_top),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_top();
        return (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'h0;
    endfunction

    // Reference behaviour: RAS is a plain queue whose back is the top entry
    task automatic model_step();
        logic [31:0] cand;
        bit          redir;
        bit          mis;
        if (rst) begin
            m_pc = c_RESET;
            m_ras.delete();
            m_mis = 1'b0;
            return;
        end
        redir = (pc_sel != 2'b00);
        case (pc_sel)
            2'd1:    cand = branch_target;
            2'd2:    cand = (m_ras.size() != 0) ? model_top() : m_pc + 32'd4;
            2'd3:    cand = alu_result & ~32'd1;
            default: cand = m_pc + 32'd4;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        mis = redir && (cand[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (trap_req || mis) m_pc = c_TRAP;
        else if (redir)      m_pc = cand;
        else if (!stall)     m_pc = m_pc + 32'd4;
        m_mis = mis;

        if (ras_flush) begin
            m_ras.delete();
        end else if (ras_push && ras_pop && m_ras.size() != 0) begin
            m_ras[m_ras.size()-1] = ras_push_addr;
        end else if (ras_push) begin
            m_ras.push_back(ras_push_addr);
            if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
        end else if (ras_pop && m_ras.size() != 0) begin
            void'(m_ras.pop_back());
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("ras_top", ras_top, model_top());
            check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
            check("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == c_DEPTH});
            check("misalign", {31'd0, misalign}, {31'd0, m_mis});
        end
    end

    task automatic clr();
        rst = 1'b0; stall = 1'b0; trap_req = 1'b0; pc_sel = 2'b00;
        branch_target = '0; alu_result = '0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0; ras_flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] exp_tops [4];
        exp_tops = '{32'h40, 32'h30, 32'h20, 32'h0};
        clr();
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("lit_reset_pc", pc, 32'h0);
        check("lit_reset_empty", {31'd0, ras_empty}, 32'd1);
        check("lit_reset_mis", {31'd0, misalign}, 32'd0);

        rst = 1'b0;
        cyc(); check("lit_seq1", pc, 32'h4);
        cyc(); check("lit_seq2", pc, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); check("lit_stall_hold", pc, 32'h8);
        end
        pc_sel = 2'b01; branch_target = 32'h40;
        cyc(); check("lit_branch_over_stall", pc, 32'h40);
        clr();

        pc_sel = 2'b11; alu_result = 32'h123;
        cyc();
`ifdef PC_MISALIGN_TRAP_EN
        check("lit_jalr_mis_pc", pc, c_TRAP);
        check("lit_jalr_mis_flag", {31'd0, misalign}, 32'd1);
`else
        check("lit_jalr_pc", pc, 32'h122);
        check("lit_jalr_flag", {31'd0, misalign}, 32'd0);
`endif
        clr();
        cyc(); check("lit_mis_pulse_end", {31'd0, misalign}, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            ras_push = 1'b1; ras_push_addr = 32'(i * 16);
            cyc();
        end
        check("lit_ras_full", {31'd0, ras_full}, 32'd1);
        check("lit_ras_top50", ras_top, 32'h50);
        clr();
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1'b1;
            cyc(); check("lit_pop_top", ras_top, exp_tops[i]);
        end
        check("lit_pop_empty", {31'd0, ras_empty}, 32'd1);
        cyc(); check("lit_pop5_noop", {31'd0, ras_empty}, 32'd1);
        clr();

        ras_push = 1'b1; ras_push_addr = 32'hA0; cyc();
        ras_pop = 1'b1; ras_push_addr = 32'hB0; cyc();
        check("lit_pushpop_top", ras_top, 32'hB0);
        clr(); ras_pop = 1'b1; cyc();
        check("lit_pushpop_cnt1", {31'd0, ras_empty}, 32'd1);
        clr(); ras_push = 1'b1; ras_push_addr = 32'hC0; cyc();
        ras_flush = 1'b1; ras_push_addr = 32'hD0; cyc();
        check("lit_flush_wins", {31'd0, ras_empty}, 32'd1);
        clr();

        pc_sel = 2'b01; branch_target = 32'h20; cyc();
        check("lit_br20", pc, 32'h20);
        pc_sel = 2'b10; cyc();
        check("lit_ret_empty", pc, 32'h24);
        clr(); ras_push = 1'b1; ras_push_addr = 32'h80; cyc();
        clr(); pc_sel = 2'b10; ras_pop = 1'b1; cyc();
        check("lit_ret_pred", pc, 32'h80);
        clr(); ras_push = 1'b1; ras_push_addr = 32'h90; cyc();
        clr(); trap_req = 1'b1; pc_sel = 2'b01; branch_target = 32'h40; stall = 1'b1; cyc();
        check("lit_trap_pc", pc, c_TRAP);
        check("lit_trap_ras", ras_top, 32'h90);
        clr(); pc_sel = 2'b11; alu_result = 32'h201; cyc();
        check("lit_jalr_even", pc, 32'h200);
        pc_sel = 2'b01; branch_target = 32'hFFFF_FFFC; cyc();
        check("lit_wrap_plus4", pc_plus4, 32'h0);
        clr(); cyc();
        check("lit_wrap_pc", pc, 32'h0);
        pc_sel = 2'b11; alu_result = 32'h123; trap_req = 1'b1; cyc();
        check("lit_trap_jalr_pc", pc, c_TRAP);
        clr(); pc_sel = 2'b01; branch_target = 32'h42; cyc();
`ifdef PC_MISALIGN_TRAP_EN
        check("lit_br_mis", pc, c_TRAP);
`else
        check("lit_br_bit1", pc, 32'h42);
`endif
        clr(); ras_push = 1'b1; ras_push_addr = 32'h70; cyc();
        clr(); rst = 1'b1; cyc();
        check("lit_rst_mid_pc", pc, c_RESET);
        check("lit_rst_mid_ras", {31'd0, ras_empty}, 32'd1);
        clr(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
